// File: rtl/mux_nx1_pkg.sv
// Shared constants, pointer type and width helper for the N-to-1 round-robin mux.
package mux_nx1_pkg;

  localparam int unsigned MODE_RR     = 0;
  localparam int unsigned MODE_STRICT = 1;

  // Wide enough for the largest supported channel count (16).
  localparam int unsigned PTR_W = 4;

  typedef logic [PTR_W-1:0] ptr_t;

  // Ceiling log2 with a floor of 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: rotating first-valid search (MODE_RR) or
// wait-on-current-channel strict rotation (MODE_STRICT).
module rr_arbiter
  import mux_nx1_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = MODE_RR
) (
  input  logic [N-1:0] req,
  input  ptr_t         ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output ptr_t         gnt_idx,
  output logic         any
);

  int unsigned w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    if (en) begin
      if (MODE == MODE_STRICT) begin
        w_idx = int'(ptr);
        if (w_idx < N && req[w_idx]) begin
          gnt[w_idx] = 1'b1;
          gnt_idx    = ptr;
          any        = 1'b1;
        end
      end else begin
        // Walk channels starting at ptr; first requester wins.
        for (int unsigned i = 0; i < N; i++) begin
          w_idx = int'(ptr) + i;
          if (w_idx >= N) w_idx = w_idx - N;
          if (!any && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            gnt_idx    = ptr_t'(w_idx);
            any        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-to-1 registered mux with valid/ready flow control and rotating channel selection.
// Optional build macro MUX_NX1_IDLE_ZERO_EN clears out on idle load cycles.
module mux_nx1_rr
  import mux_nx1_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = MODE_RR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   valid,
  output logic [N-1:0]   pop,
  output logic [W-1:0]   out,
  output logic           validout,
  input  logic           out_ready
);

  localparam int unsigned PtrW = clog2(N);

  ptr_t         r_ptr;
  logic [W-1:0] r_out;
  logic         r_validout;

  logic         w_load;
  logic         w_en;
  logic [N-1:0] w_gnt;
  ptr_t         w_gnt_idx;
  logic         w_any;
  ptr_t         w_ptr_nxt;
  logic [W-1:0] w_sel_data;

  assign w_load = !r_validout || out_ready;
  // Gating with reset keeps pop quiet while the block is being reset.
  assign w_en   = w_load && !reset;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req     (valid),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_ptr_nxt = (w_gnt_idx == ptr_t'(N - 1)) ? '0 : ptr_t'(w_gnt_idx + ptr_t'(1));

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_gnt[k]) w_sel_data = w_sel_data | in_data[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_out      <= '0;
      r_validout <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_out      <= w_sel_data;
        r_validout <= 1'b1;
      end else begin
        r_validout <= 1'b0;
`ifdef MUX_NX1_IDLE_ZERO_EN
        r_out      <= '0;
`else
        r_out      <= r_out;
`endif
      end
    end
  end

  assign pop      = w_gnt;
  assign out      = r_out;
  assign validout = r_validout;

`ifndef SYNTHESIS
  a_pop_onehot : assert property (@(posedge clk) $onehot0(pop));
  a_pop_reset  : assert property (@(posedge clk) reset |-> (pop == '0));
  a_ptr_range  : assert property (@(posedge clk) disable iff (reset) int'(r_ptr) < N);
  a_ptr_width  : assert property (@(posedge clk) PtrW <= PTR_W);
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr: one MODE_RR and one MODE_STRICT instance on shared inputs.
module tb_mux_nx1_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   valid;
  logic           out_ready;
  logic [N-1:0]   pop_rr, pop_st;
  logic [W-1:0]   out_rr, out_st;
  logic           vo_rr, vo_st;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(N), .W(W), .MODE(0)) u_dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .valid(valid),
    .pop(pop_rr), .out(out_rr), .validout(vo_rr), .out_ready(out_ready)
  );

  mux_nx1_rr #(.N(N), .W(W), .MODE(1)) u_dut_st (
    .clk(clk), .reset(reset), .in_data(in_data), .valid(valid),
    .pop(pop_st), .out(out_st), .validout(vo_st), .out_ready(out_ready)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  int           m_ptr[2];
  logic         m_vo[2];
  logic [W-1:0] m_out[2];
  logic [W-1:0] sb_rr[$];
  logic [W-1:0] sb_st[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = base + W'(k);
  endtask

  // One clock: check at negedge against the model, then advance the model past posedge.
  task automatic cycle();
    int           nptr[2];
    logic         nvo[2];
    logic [W-1:0] nout[2];
    logic [N-1:0] epop, dpop;
    logic [W-1:0] dout, exp_w;
    logic         dvo;
    int           g, idx;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      dpop = (m == 0) ? pop_rr : pop_st;
      dout = (m == 0) ? out_rr : out_st;
      dvo  = (m == 0) ? vo_rr : vo_st;
      epop = '0;
      nptr[m] = m_ptr[m];
      nvo[m]  = m_vo[m];
      nout[m] = m_out[m];
      g = -1;
      if (reset) begin
        nptr[m] = 0;
        nvo[m]  = 1'b0;
        nout[m] = '0;
      end else if (!m_vo[m] || out_ready) begin
        if (m == 0) begin
          for (int i = 0; i < N; i++) begin
            idx = (m_ptr[m] + i) % N;
            if (g < 0 && valid[idx]) g = idx;
          end
        end else if (valid[m_ptr[m]]) begin
          g = m_ptr[m];
        end
        if (g >= 0) begin
          epop[g] = 1'b1;
          nout[m] = in_data[g*W +: W];
          nvo[m]  = 1'b1;
          nptr[m] = (g + 1) % N;
        end else begin
          nvo[m] = 1'b0;
`ifdef MUX_NX1_IDLE_ZERO_EN
          nout[m] = '0;
`endif
        end
      end
      if (chk_on) begin
        check_eq($sformatf("pop_m%0d", m), 32'(dpop), 32'(epop));
        check_eq($sformatf("validout_m%0d", m), 32'(dvo), 32'(m_vo[m]));
        check_eq($sformatf("out_m%0d", m), 32'(dout), 32'(m_out[m]));
        if (dvo && out_ready) begin
          if (m == 0) begin
            check_eq("sb_nonempty_m0", 32'(sb_rr.size() != 0), 32'd1);
            if (sb_rr.size() != 0) begin
              exp_w = sb_rr.pop_front();
              check_eq("sb_data_m0", 32'(dout), 32'(exp_w));
            end
          end else begin
            check_eq("sb_nonempty_m1", 32'(sb_st.size() != 0), 32'd1);
            if (sb_st.size() != 0) begin
              exp_w = sb_st.pop_front();
              check_eq("sb_data_m1", 32'(dout), 32'(exp_w));
            end
          end
        end
      end
      if (g >= 0) begin
        if (m == 0) sb_rr.push_back(nout[m]);
        else        sb_st.push_back(nout[m]);
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = nptr[m];
      m_vo[m]  = nvo[m];
      m_out[m] = nout[m];
    end
    if (reset) begin
      sb_rr.delete();
      sb_st.delete();
    end
    chk_on = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0;
      m_vo[m]  = 1'b0;
      m_out[m] = '0;
    end
    reset = 1'b1; valid = '0; out_ready = 1'b1;
    set_data(8'h10);
    run(2);
    // Idle after reset.
    reset = 1'b0;
    run(5);
    // All channels valid: strict 0,1,2,3,0 ordering, then drain to idle.
    valid = 4'b1111;
    run(5);
    valid = 4'b0000;
    run(3);
    // Sparse requests after re-aligning pointers.
    reset = 1'b1; run(1); reset = 1'b0;
    set_data(8'h20);
    valid = 4'b0101;
    run(5);
    // Strict mode stalls at channel 2 until it becomes valid.
    reset = 1'b1; run(1); reset = 1'b0;
    set_data(8'h30);
    valid = 4'b1011;
    run(4);
    valid = 4'b1111;
    run(2);
    // Downstream stall: valid changes must not matter while stalled.
    out_ready = 1'b0;
    valid = 4'b0010; run(1);
    valid = 4'b1000; run(1);
    valid = 4'b0001; run(1);
    out_ready = 1'b1;
    valid = 4'b1111;
    set_data(8'h40);
    run(3);
    // Reset with a word in flight and ptr at 2.
    reset = 1'b1; run(1); reset = 1'b0;
    run(2);
    reset = 1'b1; run(1); reset = 1'b0;
    set_data(8'h50);
    run(3);
    // Randomised traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      valid     = N'($urandom_range(0, (1 << N) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      cycle();
    end
    reset = 1'b0; valid = '0; out_ready = 1'b1;
    run(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 registered multiplexer with valid/ready flow control and rotating channel selection. It is the general successor of the two-input lane mux in the PCIe physical-layer datapath. It merges N byte or word channels into one stream, either skipping idle channels (work-conserving round-robin) or visiting channels in strict order (lane un-striping). The output is registered, and each channel receives a one-cycle pop strobe when its word is consumed.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel.
- `MODE`, default 0: 0 = round-robin that skips invalid channels; 1 = strict rotation that waits on the current channel.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_data` input, N*W bits: channel k occupies bits [k*W +: W].
- `valid` input, N bits: channel k holds a word.
- `pop` output, N bits: combinational one-hot (or zero); channel k's word is consumed this cycle.
- `out` output, W bits: registered output data.
- `validout` output, 1 bit: registered; `out` holds a word.
- `out_ready` input, 1 bit: downstream accepts `out` this cycle.

## Operation
- Load condition: `load = !validout || out_ready`.
- Each cycle with `load`, the arbiter selects at most one channel `g`:
  - `MODE` 0: `g` is the first set bit of `valid` searching from `ptr`, wrapping modulo N.
  - `MODE` 1: `g = ptr` if `valid[ptr]`; otherwise no grant, and `ptr` does not move.
- On a grant:
  - `pop[g]` = 1.
  - Next cycle: `out` = channel `g`'s word and `validout` = 1.
  - `ptr` becomes (g+1) mod N.
- Without a grant while `load`: `validout` becomes 0; `out` behaves per Configuration.
- When `!load` (stalled): `pop` = 0; `out`, `validout` and `ptr` hold.
- Wrap-around: `ptr` = N-1 followed by a grant to N-1 sets `ptr` to 0.
- `MODE` 0 with all bits of `valid` set gives strict order 0,1,…,N-1,0,…
- `valid` changing while stalled has no effect until `load` is true again.
- Reset: `out` = 0, `validout` = 0, `ptr` = 0, `pop` = 0. Reset overrides every other input, including an in-flight word, which is discarded.
- Reset on the same cycle as a valid `out_ready`: the reset values win and no pop is issued.

## Timing
- Latency: 1 cycle from `pop[g]` to `validout` = 1 with that data.
- Throughput: 1 word per cycle while `out_ready` = 1 and a grant is available.
- `pop` is combinational from `valid`, `ptr`, `validout` and `out_ready`. `out_ready` must not depend combinationally on `pop`.
- `pop` is never asserted while `reset` = 1.
- Upstream must present the next word, or deassert `valid`, in the cycle after its pop.

## Configuration
- `MUX_NX1_IDLE_ZERO_EN` defined: on a load cycle with no grant, `out` is cleared to 0 together with `validout` = 0.
- Not defined: `out` holds its last value when idle. Only `validout` drops, which saves the clear logic.
- The macro has no effect on `validout`, `pop` or `ptr`.

## Structure
- Package `mux_nx1_pkg`:
  - `MODE_RR` = 0 and `MODE_STRICT` = 1 constants.
  - Pointer width function `clog2(N)`.
  - Typedef for the pointer.
- Sub-module `rr_arbiter`:
  - Parameters N and MODE.
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt[N]` one-hot, `gnt_idx`, `any`.
  - Purely combinational; `ptr` and the data register stay in the top.

## Test plan
- Reset, then `valid` = 0: after the reset cycle, `out` = 0, `validout` = 0 and `pop` = 0 for 5 cycles.
- N=4, MODE=0, all valid, data = 0x10..0x13, `out_ready` = 1: `pop` sequence 0001, 0010, 0100, 1000, 0001; `out` 0x10, 0x11, 0x12, 0x13, each one cycle after its pop.
- MODE=0, `valid` = 0101: grants go to channels 0, 2, 0, 2; channels 1 and 3 are never popped; `validout` stays 1.
- MODE=1, `valid` = 1011: channels 0 and 1 are popped, then the block stalls at `ptr` = 2 with `validout` = 0. Raising `valid[2]` gives a pop of channel 2 on that same cycle.
- `out_ready` held 0 for 3 cycles with `validout` = 1: `out` is stable, `pop` = 0 and `ptr` is unchanged. On release, the next channel is granted.
- Reset asserted while `validout` = 1 and `ptr` = 2: the next cycle shows `validout` = 0, `out` = 0, and the first subsequent grant goes to channel 0.
- Idle-clear check (run twice): with `MUX_NX1_IDLE_ZERO_EN` defined, `out` becomes 0 after the last word drains; without it, `out` holds that last word.
